// File: rtl/tx_pacing_scheduler.sv
// Periodic transmit-request scheduler: decodes the switch word into rate, redundancy and
// segment settings and walks segment/copy indices with a req/ack handshake to the builder.
module tx_pacing_scheduler #(
  parameter int unsigned CntW      = 28,
  parameter int unsigned SegW      = 16,
  parameter int unsigned RedW      = 8,
  parameter int unsigned OvrW      = 16,
  parameter int unsigned SegStep   = 50,
  parameter int unsigned MinPeriod = 30
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [7:0]      switches_i,
  output logic            tx_req_o,
  input  logic            tx_ack_i,
  output logic [SegW-1:0] seg_idx_o,
  output logic [RedW-1:0] copy_idx_o,
  output logic            group_done_o,
  output logic [OvrW-1:0] overrun_cnt_o,
  output logic [CntW-1:0] cur_period_o,
  output logic [SegW-1:0] cur_seg_max_o,
  output logic [RedW-1:0] cur_red_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tx_req_q, tx_req_d;
  logic [SegW-1:0] seg_q, seg_d;
  logic [RedW-1:0] copy_q, copy_d;
  logic            group_done_q, group_done_d;
  logic [OvrW-1:0] ovr_q, ovr_d;
  logic [CntW-1:0] period_q, period_d;
  logic [SegW-1:0] seg_max_q, seg_max_d;
  logic [RedW-1:0] red_q, red_d;

  logic [CntW-1:0] sw_period;
  logic [SegW-1:0] sw_seg_max;
  logic [RedW-1:0] sw_red;
  logic            tick, last_copy, last_seg;

  always_comb begin
    case (switches_i[3:0])
      4'h0:    sw_period = CntW'(124999999);
      4'h1:    sw_period = CntW'(62499999);
      4'h2:    sw_period = CntW'(12499999);
      4'h3:    sw_period = CntW'(6249999);
      4'h4:    sw_period = CntW'(2499999);
      4'h5:    sw_period = CntW'(1249999);
      4'h6:    sw_period = CntW'(624999);
      4'h7:    sw_period = CntW'(249999);
      4'h8:    sw_period = CntW'(124999);
      4'h9:    sw_period = CntW'(62499);
      4'hA:    sw_period = CntW'(24999);
      4'hB:    sw_period = CntW'(12499);
      4'hC:    sw_period = CntW'(6249);
      4'hD:    sw_period = CntW'(2499);
      4'hE:    sw_period = CntW'(1249);
      default: sw_period = CntW'(MinPeriod);
    endcase
    sw_red     = RedW'({switches_i[5:4], 1'b1});
    sw_seg_max = (switches_i[7:6] == 2'd0) ? SegW'(1)
                                           : SegW'(switches_i[7:6]) * SegW'(SegStep);
  end

  // >= rather than == so a relatch to a shorter period mid-count cannot run the counter away
  assign tick      = (state_q == StRun) && (cnt_q >= period_q);
  assign last_copy = (copy_q == red_q - RedW'(1));
  assign last_seg  = (seg_q == seg_max_q - SegW'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_req_d     = tx_req_q;
    seg_d        = seg_q;
    copy_d       = copy_q;
    group_done_d = 1'b0;
    ovr_d        = ovr_q;
    period_d     = period_q;
    seg_max_d    = seg_max_q;
    red_d        = red_q;

    unique case (state_q)
      StIdle: begin
        cnt_d    = '0;
        tx_req_d = 1'b0;
        if (en_i) begin
          state_d   = StRun;
          seg_d     = '0;
          copy_d    = '0;
          period_d  = sw_period;
          seg_max_d = sw_seg_max;
          red_d     = sw_red;
        end
      end
      StRun: begin
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
        if (tick && tx_req_q && !(&ovr_q)) begin
          ovr_d = ovr_q + OvrW'(1);
        end
        if (tx_req_q) begin
          if (tx_ack_i) begin
            tx_req_d = 1'b0;
            copy_d   = copy_q + RedW'(1);
            if (last_copy) begin
              copy_d = '0;
              seg_d  = seg_q + SegW'(1);
              if (last_seg) begin
                seg_d        = '0;
                group_done_d = 1'b1;
                period_d     = sw_period;
                seg_max_d    = sw_seg_max;
                red_d        = sw_red;
              end
            end
            if (!en_i) state_d = StIdle;
          end
        end else if (!en_i) begin
          state_d = StIdle;
        end else if (tick) begin
          tx_req_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tx_req_q     <= 1'b0;
      seg_q        <= '0;
      copy_q       <= '0;
      group_done_q <= 1'b0;
      ovr_q        <= '0;
      period_q     <= '0;
      seg_max_q    <= SegW'(1);
      red_q        <= RedW'(1);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_req_q     <= tx_req_d;
      seg_q        <= seg_d;
      copy_q       <= copy_d;
      group_done_q <= group_done_d;
      ovr_q        <= ovr_d;
      period_q     <= period_d;
      seg_max_q    <= seg_max_d;
      red_q        <= red_d;
    end
  end

  assign tx_req_o      = tx_req_q;
  assign seg_idx_o     = seg_q;
  assign copy_idx_o    = copy_q;
  assign group_done_o  = group_done_q;
  assign overrun_cnt_o = ovr_q;
  assign cur_period_o  = period_q;
  assign cur_seg_max_o = seg_max_q;
  assign cur_red_o     = red_q;

endmodule

// File: tb/tb_tx_pacing_scheduler.sv
// Directed bench for tx_pacing_scheduler: rate timing, index walking, config relatch,
// overrun counting and asynchronous reset during a pending request.
module tb_tx_pacing_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  sw;
  logic        tx_req;
  logic        tx_ack;
  logic        auto_ack;
  logic        man_ack;
  logic [15:0] seg_idx;
  logic [7:0]  copy_idx;
  logic        group_done;
  logic [15:0] overrun_cnt;
  logic [27:0] cur_period;
  logic [15:0] cur_seg_max;
  logic [7:0]  cur_red;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs    = 0;
  int gd    = 0;

  tx_pacing_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .switches_i    (sw),
    .tx_req_o      (tx_req),
    .tx_ack_i      (tx_ack),
    .seg_idx_o     (seg_idx),
    .copy_idx_o    (copy_idx),
    .group_done_o  (group_done),
    .overrun_cnt_o (overrun_cnt),
    .cur_period_o  (cur_period),
    .cur_seg_max_o (cur_seg_max),
    .cur_red_o     (cur_red)
  );

  always #4 clk = ~clk;

  assign tx_ack = auto_ack ? tx_req : man_ack;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_req && tx_ack) hs <= hs + 1;
    if (group_done) gd <= gd + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int limit, output int t);
    int n = 0;
    while (!tx_req && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(tx_req), 32'd1);
    t = cyc;
  endtask

  task automatic go_idle();
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t0, t1, ten, hs0, gd0, n;
    rst = 1'b1; en = 1'b0; sw = 8'h0F; auto_ack = 1'b1; man_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(tx_req), 32'd0);
    check("rst_seg", 32'(seg_idx), 32'd0);
    check("rst_copy", 32'(copy_idx), 32'd0);
    check("rst_gd", 32'(group_done), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    check("rst_period", 32'(cur_period), 32'd0);
    check("rst_segmax", 32'(cur_seg_max), 32'd1);
    check("rst_red", 32'(cur_red), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 1: fastest rate, one frame per group
    en = 1'b1; ten = cyc;
    wait_req(100, t0);
    check("t1_latency", 32'(t0 - ten), 32'd32);
    check("t1_period", 32'(cur_period), 32'd30);
    check("t1_seg", 32'(seg_idx), 32'd0);
    check("t1_copy", 32'(copy_idx), 32'd0);
    @(negedge clk);
    check("t1_req_clr", 32'(tx_req), 32'd0);
    check("t1_gd", 32'(group_done), 32'd1);
    wait_req(100, t1);
    check("t1_interval", 32'(t1 - t0), 32'd31);
    go_idle();

    // 2: three copies per segment
    sw = 8'h1F; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req(100, t0);
      check("t2_copy", 32'(copy_idx), 32'(k % 3));
      check("t2_seg", 32'(seg_idx), 32'd0);
      @(negedge clk);
      check("t2_gd", 32'(group_done), 32'((k % 3) == 2));
    end
    check("t2_red", 32'(cur_red), 32'd3);
    go_idle();

    // 3: fifty segments, single copy
    sw = 8'h4F; en = 1'b1; gd0 = gd;
    for (int k = 0; k < 51; k++) begin
      wait_req(100, t0);
      check("t3_seg", 32'(seg_idx), 32'(k % 50));
      @(negedge clk);
    end
    check("t3_gd_count", 32'(gd - gd0), 32'd1);
    go_idle();

    // 4: builder stalls for 100 clocks
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    auto_ack = 1'b0; man_ack = 1'b0; sw = 8'h0F; en = 1'b1; hs0 = hs;
    wait_req(100, t0);
    repeat (100) @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0; en = 1'b0;
    check("t4_req_clr", 32'(tx_req), 32'd0);
    repeat (40) @(negedge clk);
    check("t4_ovr", 32'(overrun_cnt), 32'd3);
    check("t4_handshakes", 32'(hs - hs0), 32'd1);
    check("t4_req_idle", 32'(tx_req), 32'd0);

    // 5: switch change mid-group takes effect only at group_done
    auto_ack = 1'b1; sw = 8'h4F; en = 1'b1;
    wait_req(100, t0);
    @(negedge clk);
    sw = 8'h1E;
    for (int k = 0; k < 3; k++) begin
      wait_req(100, t0);
      @(negedge clk);
    end
    check("t5_hold_period", 32'(cur_period), 32'd30);
    check("t5_hold_segmax", 32'(cur_seg_max), 32'd50);
    check("t5_hold_red", 32'(cur_red), 32'd1);
    n = 0;
    while (!group_done && n < 2500) begin
      @(negedge clk);
      n++;
    end
    check("t5_gd_seen", 32'(group_done), 32'd1);
    check("t5_new_period", 32'(cur_period), 32'd1249);
    check("t5_new_red", 32'(cur_red), 32'd3);
    check("t5_new_segmax", 32'(cur_seg_max), 32'd1);
    check("t5_seg_wrap", 32'(seg_idx), 32'd0);
    check("t5_ovr_hold", 32'(overrun_cnt), 32'd3);
    go_idle();

    // 6: asynchronous reset while a request is pending
    sw = 8'h1F; en = 1'b1;
    wait_req(100, t0);
    @(negedge clk);
    auto_ack = 1'b0; man_ack = 1'b0;
    wait_req(100, t0);
    check("t6_pending_copy", 32'(copy_idx), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_req", 32'(tx_req), 32'd0);
    check("t6_copy", 32'(copy_idx), 32'd0);
    check("t6_seg", 32'(seg_idx), 32'd0);
    check("t6_ovr", 32'(overrun_cnt), 32'd0);
    check("t6_period", 32'(cur_period), 32'd0);
    check("t6_red", 32'(cur_red), 32'd1);
    @(negedge clk);
    rst = 1'b0; auto_ack = 1'b1;
    wait_req(100, t0);
    check("t6_restart_seg", 32'(seg_idx), 32'd0);
    check("t6_restart_copy", 32'(copy_idx), 32'd0);
    check("t6_restart_red", 32'(cur_red), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
